// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the processor fetch/load bus.
//   Registered reads with one cycle of latency, byte-masked writes, a RAM of
//   WORDS 32-bit words and a small IO page.
//   Optional build macro MEM_IO_STATS_EN adds the CYCLES and RDCOUNT counters.
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   mem_addr   byte address; bit IO_BIT selects IO (1) or RAM (0)
//   mem_rstrb  read strobe, one cycle per request
//   mem_rdata  read data, valid the cycle after the strobe and held until the next strobe
//   mem_wdata  write data
//   mem_wmask  byte-lane write enables; bit i covers mem_wdata[8i+7:8i]
//   leds       LED register (IO offset 0x00)
module mem_responder #(
  parameter int WORDS  = 256,
  parameter int IO_BIT = 22
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [4:0]  leds
);
  localparam int AW = $clog2(WORDS);
  logic [31:0]   ram [WORDS];
  logic [AW-1:0] idx;
  logic          io_sel;
  logic [5:0]    off;
  logic [31:0]   io_rd;
  logic [31:0]   cycles;
  logic [31:0]   rdcount;
  logic          unused_addr;
  assign idx         = mem_addr[AW+1:2];
  assign io_sel      = mem_addr[IO_BIT];
  assign off         = mem_addr[7:2];
  // Address bits outside the decoded fields are ignored by design.
  assign unused_addr = ^mem_addr;
  assign io_rd = off == 6'd0 ? {27'b0, leds} :
                 off == 6'd1 ? cycles :
                 off == 6'd2 ? rdcount : 32'b0;
`ifdef MEM_IO_STATS_EN
  // Counters wrap silently; a read sees the value before this edge's increment.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cycles  <= '0;
      rdcount <= '0;
    end else begin
      cycles  <= cycles + 32'd1;
      rdcount <= rdcount + {31'b0, mem_rstrb};
    end
`else
  assign cycles  = '0;
  assign rdcount = '0;
`endif
  // Block-RAM style array: no reset, byte-enable write.
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (!io_sel && mem_wmask[i]) ram[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
  // Reading the array in the same edge as a write returns the old word.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) mem_rdata <= '0;
    else if (mem_rstrb) mem_rdata <= io_sel ? io_rd : ram[idx];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) leds <= '0;
    else if (io_sel && off == 6'd0 && mem_wmask[0]) leds <= mem_wdata[4:0];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
module tb_mem_responder;
`ifdef MEM_IO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [4:0]  leds;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q;
  logic [31:0] c1;
  logic [31:0] c2;
  mem_responder #(.WORDS(256), .IO_BIT(22)) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .leds(leds)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    tick();
    mem_wmask = 4'h0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    mem_addr  = a;
    mem_rstrb = 1'b1;
    tick();
    mem_rstrb = 1'b0;
    r = mem_rdata;
  endtask
  initial begin
    resetn    = 1'b0;
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wdata = '0;
    mem_wmask = 4'h0;
    tick();
    tick();
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_leds", {27'b0, leds}, 32'h0);
    resetn = 1'b1;
    wr(32'h0, 32'h0000_0013, 4'hF);
    mem_addr  = 32'h0;
    mem_rstrb = 1'b1;
    chk("pre_edge", mem_rdata, 32'h0);
    tick();
    mem_rstrb = 1'b0;
    chk("read_lat1", mem_rdata, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      mem_addr = 32'h10;
      tick();
      chk("hold", mem_rdata, 32'h0000_0013);
    end
    wr(32'h10, 32'hAABB_CCDD, 4'hF);
    wr(32'h11, 32'h1122_3344, 4'h5);
    rd(32'h10, q);
    chk("byte_mask", q, 32'hAA22_CC44);
    wr(32'h20, 32'h1, 4'hF);
    mem_addr  = 32'h20;
    mem_wdata = 32'h2;
    mem_wmask = 4'hF;
    mem_rstrb = 1'b1;
    tick();
    mem_rstrb = 1'b0;
    mem_wmask = 4'h0;
    chk("rbw_old", mem_rdata, 32'h1);
    rd(32'h20, q);
    chk("rbw_new", q, 32'h2);
    wr(32'h400, 32'h5, 4'hF);
    rd(32'h0, q);
    chk("alias", q, 32'h5);
    wr(32'h0040_0000, 32'h1F, 4'h1);
    chk("leds_wr", {27'b0, leds}, 32'h1F);
    wr(32'h0040_0000, 32'h0, 4'hE);
    chk("leds_mask", {27'b0, leds}, 32'h1F);
    rd(32'h0040_0000, q);
    chk("leds_rd", q, 32'h1F);
    rd(32'h0040_0010, q);
    chk("io_other", q, 32'h0);
    rd(32'h0, q);
    mem_addr  = 32'h10;
    mem_rstrb = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rdata", mem_rdata, 32'h0);
    chk("async_leds", {27'b0, leds}, 32'h0);
    tick();
    chk("rst_discard", mem_rdata, 32'h0);
    mem_rstrb = 1'b0;
    resetn    = 1'b1;
    rd(32'h10, q);
    chk("keep_10", q, 32'hAA22_CC44);
    rd(32'h20, q);
    chk("keep_20", q, 32'h2);
    rd(32'h0, q);
    chk("keep_0", q, 32'h5);
    rd(32'h0040_0008, q);
    chk("rdcount", q, STATS ? 32'd3 : 32'd0);
    rd(32'h0040_0004, c1);
    for (int i = 0; i < 9; i++) tick();
    rd(32'h0040_0004, c2);
    chk("cycles_delta", c2 - c1, STATS ? 32'd10 : 32'd0);
    if (!STATS) chk("cycles_zero", c2, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
